// File: rtl/mnist_cls_pkg.sv
// Shared constants and FSM state type for the classifier output stage.
package mnist_cls_pkg;

    localparam int N_CLASS_DEF   = 10;
    localparam int SCORE_W_DEF   = 9;
    localparam int PCT_SCALE_DEF = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } cls_state_t;

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider: one quotient bit per cycle, fixed NUM_W-cycle latency.
// A zero divisor still runs the full sequence and reports quotient 0.
module seq_udiv #(
    parameter int NUM_W = 16,
    parameter int DEN_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] q_r;
    logic [DEN_W-1:0] rem_r;
    logic [DEN_W-1:0] den_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             zero_r;

    logic             go;
    logic [NUM_W-1:0] cur_src;
    logic [DEN_W-1:0] cur_rem;
    logic [DEN_W-1:0] cur_den;
    logic [DEN_W:0]   trial;
    logic             fits;
    logic [DEN_W-1:0] rem_nxt;
    logic [NUM_W-1:0] q_nxt;

    // The first iteration runs on the start cycle straight from the inputs,
    // so the last quotient bit lands exactly NUM_W edges after start.
    assign go = start && !busy_r;

    always_comb begin
        cur_src = go ? dividend : q_r;
        cur_rem = go ? '0 : rem_r;
        cur_den = go ? divisor : den_r;
        trial   = {cur_rem, cur_src[NUM_W-1]};
        fits    = (trial >= {1'b0, cur_den});
        rem_nxt = fits ? DEN_W'(trial - {1'b0, cur_den}) : DEN_W'(trial);
        q_nxt   = {cur_src[NUM_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r    <= '0;
            rem_r  <= '0;
            den_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (go) begin
                q_r    <= q_nxt;
                rem_r  <= rem_nxt;
                den_r  <= divisor;
                zero_r <= (divisor == '0);
                cnt_r  <= CNT_W'(NUM_W - 1);
                busy_r <= 1'b1;
            end else if (busy_r) begin
                q_r   <= q_nxt;
                rem_r <= rem_nxt;
                cnt_r <= cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = zero_r ? '0 : q_r;

endmodule

// File: rtl/argmax_conf_seq.sv
// Sequential argmax / runner-up / total scan of a score vector, followed by
// an iterative confidence division max*PCT_SCALE/total.
module argmax_conf_seq
    import mnist_cls_pkg::*;
#(
    parameter int N_CLASS   = N_CLASS_DEF,
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int PCT_SCALE = PCT_SCALE_DEF,
    parameter int CONF_W    = 12,
    localparam int IDX_W    = $clog2(N_CLASS),
    localparam int SUM_W    = SCORE_W + $clog2(N_CLASS),
    localparam int SCL_W    = $clog2(PCT_SCALE + 1),
    localparam int NUM_W    = SCORE_W + SCL_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CLASS*SCORE_W-1:0] score_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           max_index,
    output logic [CONF_W-1:0]          confidence,
    output logic [SCORE_W-1:0]         margin,
    output logic [SUM_W-1:0]           total
);

    // Handshakes: a transfer happens on a posedge where valid && ready are both
    // high; valid never depends on ready, and the DONE payload is held until taken.

    cls_state_t state, state_next;

    logic [N_CLASS*SCORE_W-1:0] vec_r;
    logic [SCORE_W-1:0]         max_r;
    logic [SCORE_W-1:0]         sec_r;
    logic [SUM_W-1:0]           sum_r;
    logic [IDX_W-1:0]           idx_r;
    logic [IDX_W-1:0]           cnt_r;

    logic [SCORE_W-1:0] s_cur;
    logic               scan_last;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [NUM_W-1:0]   dividend;
    logic [NUM_W-1:0]   quotient;
    logic [CONF_W-1:0]  conf_sat;

    // The vector shifts right each SCAN cycle, so the current class is always the low slot.
    assign s_cur     = vec_r[SCORE_W-1:0];
    assign scan_last = (cnt_r == IDX_W'(N_CLASS - 1));
    assign dividend  = NUM_W'(max_r) * NUM_W'(PCT_SCALE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SCAN;
            SCAN:    if (scan_last) state_next = DIV;
            DIV:     if (div_done)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        div_start = (state == DIV) && !div_busy && !div_done;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_r      <= '0;
            max_r      <= '0;
            sec_r      <= '0;
            sum_r      <= '0;
            idx_r      <= '0;
            cnt_r      <= '0;
            max_index  <= '0;
            confidence <= '0;
            margin     <= '0;
            total      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec_r <= score_in;
                        max_r <= '0;
                        sec_r <= '0;
                        sum_r <= '0;
                        idx_r <= '0;
                        cnt_r <= '0;
                    end
                end
                SCAN: begin
                    // Strict compare: an equal score never displaces the earlier index.
                    if (s_cur > max_r) begin
                        sec_r <= max_r;
                        max_r <= s_cur;
                        idx_r <= cnt_r;
                    end else if (s_cur > sec_r) begin
                        sec_r <= s_cur;
                    end
                    sum_r <= sum_r + SUM_W'(s_cur);
                    vec_r <= vec_r >> SCORE_W;
                    cnt_r <= cnt_r + IDX_W'(1);
                end
                DIV: begin
                    if (div_done) begin
                        max_index  <= idx_r;
                        confidence <= conf_sat;
                        margin     <= max_r - sec_r;
                        total      <= sum_r;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_udiv #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (sum_r),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    generate
        if (NUM_W > CONF_W) begin : g_sat
            assign conf_sat = (|quotient[NUM_W-1:CONF_W]) ? {CONF_W{1'b1}} : quotient[CONF_W-1:0];
        end else begin : g_ext
            assign conf_sat = CONF_W'(quotient);
        end
    endgenerate

endmodule
